// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
// The result is computed at the start edge and parked in temp_hi/temp_lo.
// A busy counter then models the multi-cycle latency before HI/LO commit.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_MDUout,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    logic        state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] temp_hi_q, temp_hi_d;
    logic [31:0] temp_lo_q, temp_lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    assign prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign prod_u = {32'b0, E_A} * {32'b0, E_B};

    // Dividers; zero divisor is handled by the caller, and the one signed
    // overflow case is pinned explicitly rather than left to the simulator.
    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (E_B != 32'd0) begin
            quot_u = E_A / E_B;
            rem_u  = E_A % E_B;
            if (E_A == 32'h8000_0000 && E_B == 32'hFFFF_FFFF) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(E_A) / $signed(E_B);
                rem_s  = $signed(E_A) % $signed(E_B);
            end
        end
    end

    assign E_Busy  = (state_q == StRun);
    assign E_Start = (state_q == StIdle) && (E_MDUop >= OpMult) && (E_MDUop <= OpDivu);
    assign E_HI    = hi_q;
    assign E_LO    = lo_q;

    // Move-from read port; reads current HI/LO even while busy.
    always_comb begin
        case (E_MDUop)
            OpMfhi:  E_MDUout = hi_q;
            OpMflo:  E_MDUout = lo_q;
            default: E_MDUout = 32'd0;
        endcase
    end

    // Next-state: accept ops only in IDLE, count down and commit in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        case (state_q)
            StIdle: begin
                if (E_Start) begin
                    state_d = StRun;
                    case (E_MDUop)
                        OpMult: begin
                            {temp_hi_d, temp_lo_d} = prod_s;
                            cnt_d = 4'(MULT_CYCLES);
                        end
                        OpMultu: begin
                            {temp_hi_d, temp_lo_d} = prod_u;
                            cnt_d = 4'(MULT_CYCLES);
                        end
                        OpDiv: begin
                            // Divide by zero commits the pre-op HI/LO back.
                            if (E_B == 32'd0) {temp_hi_d, temp_lo_d} = {hi_q, lo_q};
                            else              {temp_hi_d, temp_lo_d} = {rem_s, quot_s};
                            cnt_d = 4'(DIV_CYCLES);
                        end
                        default: begin
                            if (E_B == 32'd0) {temp_hi_d, temp_lo_d} = {hi_q, lo_q};
                            else              {temp_hi_d, temp_lo_d} = {rem_u, quot_u};
                            cnt_d = 4'(DIV_CYCLES);
                        end
                    endcase
                end else if (E_MDUop == OpMthi) begin
                    hi_d = E_A;
                end else if (E_MDUop == OpMtlo) begin
                    lo_d = E_A;
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = temp_hi_q;
                    lo_d    = temp_lo_q;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State registers; reset abandons any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu with hand-computed HI/LO results.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDUop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_Start;
    logic        E_Busy;
    logic [31:0] E_MDUout;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int n_pass  = 0;
    int n_total = 0;

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDUop (E_MDUop),
        .E_A     (E_A),
        .E_B     (E_B),
        .E_Start (E_Start),
        .E_Busy  (E_Busy),
        .E_MDUout(E_MDUout),
        .E_HI    (E_HI),
        .E_LO    (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a mult/div from IDLE, watch busy for n cycles with HI/LO held at
    // old values, then check the committed result in the first idle cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        E_MDUop = op;
        E_A     = a;
        E_B     = b;
        #1;
        check({tag, " start"}, 32'(E_Start), 32'd1);
        tick();
        E_MDUop = 4'd0;
        for (int i = 0; i < n; i++) begin
            check({tag, " busy"}, 32'(E_Busy), 32'd1);
            check({tag, " hi held"}, E_HI, old_hi);
            check({tag, " lo held"}, E_LO, old_lo);
            tick();
        end
        check({tag, " done"}, 32'(E_Busy), 32'd0);
        check({tag, " hi"}, E_HI, exp_hi);
        check({tag, " lo"}, E_LO, exp_lo);
    endtask

    initial begin
        reset   = 1'b1;
        E_MDUop = 4'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
        tick();
        tick();
        check("reset busy", 32'(E_Busy), 32'd0);
        check("reset hi", E_HI, 32'd0);
        check("reset lo", E_LO, 32'd0);
        check("reset out", E_MDUout, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10,
               32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 4'd4, 32'd7, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
        run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'd1, 32'd3, 32'd0, 32'h8000_0000);

        // Preload HI/LO, then divide by zero must leave them intact.
        E_MDUop = 4'd7;
        E_A     = 32'h11;
        tick();
        E_MDUop = 4'd8;
        E_A     = 32'h22;
        tick();
        check("mthi", E_HI, 32'h11);
        check("mtlo", E_LO, 32'h22);
        run_op("div0", 4'd4, 32'd99, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

        // mthi then mfhi the following cycle.
        E_MDUop = 4'd7;
        E_A     = 32'h1234_5678;
        tick();
        E_MDUop = 4'd5;
        #1;
        check("mfhi", E_MDUout, 32'h1234_5678);
        E_MDUop = 4'd6;
        #1;
        check("mflo", E_MDUout, 32'h22);

        // mult 3*4, with ops presented while busy that must be ignored.
        E_MDUop = 4'd1;
        E_A     = 32'd3;
        E_B     = 32'd4;
        #1;
        check("ign start", 32'(E_Start), 32'd1);
        tick();
        E_MDUop = 4'd8;
        E_A     = 32'hAAAA;
        #1;
        check("mtlo busy start", 32'(E_Start), 32'd0);
        tick();
        check("mtlo ignored", E_LO, 32'h22);
        E_MDUop = 4'd1;
        E_A     = 32'd5;
        E_B     = 32'd5;
        #1;
        check("mult busy start", 32'(E_Start), 32'd0);
        tick();
        E_MDUop = 4'd5;
        #1;
        check("mfhi busy old", E_MDUout, 32'h1234_5678);
        tick();
        E_MDUop = 4'd0;
        tick();
        check("ign still busy", 32'(E_Busy), 32'd1);
        tick();
        check("ign done", 32'(E_Busy), 32'd0);
        check("ign hi", E_HI, 32'd0);
        check("ign lo", E_LO, 32'd12);

        // Back-to-back: start in the very cycle busy fell.
        run_op("b2b", 4'd2, 32'h10, 32'h10, 5, 32'd0, 32'd12, 32'd0, 32'h100);

        // Reset asserted in busy cycle 4 of a div.
        E_MDUop = 4'd7;
        E_A     = 32'hDEAD;
        tick();
        E_MDUop = 4'd3;
        E_A     = 32'd100;
        E_B     = 32'd7;
        tick();
        E_MDUop = 4'd0;
        tick();
        tick();
        tick();
        check("pre-rst busy", 32'(E_Busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst busy", 32'(E_Busy), 32'd0);
        check("rst hi", E_HI, 32'd0);
        check("rst lo", E_LO, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post-rst hi", E_HI, 32'd0);
        run_op("post-rst mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits directly downstream of the decode/execute pipeline register and consumes its rs/rt operand and instruction outputs.
- Implements the MIPS mult, multu, div, divu, mfhi, mflo, mthi and mtlo instructions. Owns the HI/LO registers.
- Models multi-cycle latency with a busy counter. The hazard unit uses E_Start/E_Busy to stall younger HI/LO-touching instructions in D.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu start.
- DIV_CYCLES, 10, cycles busy stays high after a div/divu start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- E_MDUop  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- E_A  input  32  operand rs, forwarded value of E_Rsout.
- E_B  input  32  operand rt, forwarded value of E_Rtout.
- E_Start  output  1  combinational; 1 when E_MDUop is 1-4 and E_Busy=0.
- E_Busy  output  1  registered; 1 while a mult/div is in flight.
- E_MDUout  output  32  combinational: HI for op 5, LO for op 6, else 0.
- E_HI  output  32  current HI register.
- E_LO  output  32  current LO register.

Behaviour:
- Reset (async, immediate):
  - HI=0, LO=0, E_Busy=0, internal counter=0.
  - Pending temp result is discarded. E_MDUout and E_Start follow from inputs.
- States:
  - IDLE (E_Busy=0) and RUN (E_Busy=1).
  - Counter is 4 bits, wide enough for DIV_CYCLES up to 15.
- IDLE, op 1-4 at rising edge:
  - Compute the result into temp_hi/temp_lo.
  - Load counter=MULT_CYCLES or DIV_CYCLES; E_Busy<=1.
  - HI/LO are not yet changed.
- RUN, each edge: counter decrements.
- RUN, edge where counter==1:
  - HI<=temp_hi, LO<=temp_lo, E_Busy<=0.
  - Busy is therefore high for exactly N cycles after the start cycle; the new HI/LO are visible in the first cycle with E_Busy=0.
- Any op presented while E_Busy=1: ignored entirely, including 1-4 and 7/8.
  - E_Start=0 in this case.
  - mfhi/mflo while busy return the old HI/LO. The hazard unit prevents this in normal operation.
- mthi/mtlo in IDLE: HI or LO <= E_A at the edge, visible the next cycle. Busy is unaffected.
- mult: signed 32x32 to 64; HI=upper 32, LO=lower 32.
- multu: unsigned 32x32 to 64; HI=upper 32, LO=lower 32.
- div, signed:
  - LO=quotient, truncated toward zero.
  - HI=remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu, unsigned: LO=quotient, HI=remainder.
- Divide by zero (E_B=0, div or divu):
  - Unit still goes busy for DIV_CYCLES.
  - HI/LO keep their pre-op values at completion.
- Back-to-back starts: a start is accepted in the cycle E_Busy falls (IDLE), giving zero bubble between ops.
- Reset asserted mid-RUN: the unit returns to IDLE at once; no HI/LO update occurs.

Test Plan:
- Signed mult, E_A=0xFFFFFFFF, E_B=2, op=1:
  - E_Start=1 in the start cycle.
  - E_Busy=1 for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - HI/LO unchanged until then.
- Unsigned multu with the same operands, op=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- Signed div, E_A=0xFFFFFFF9 (-7), E_B=2, op=3 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divu, E_A=7, E_B=2, op=4 -> LO=3, HI=1.
- Divide by zero: divu with E_B=0 while HI=0x11, LO=0x22 -> 10 busy cycles, then HI=0x11, LO=0x22.
- Move and ignore-while-busy:
  - mthi with E_A=0x12345678, then mfhi next cycle -> E_MDUout=0x12345678.
  - mtlo 0xAAAA issued while busy -> LO unaffected.
  - mult issued while busy -> E_Start=0 and the op is not accepted.
- Reset mid-op:
  - Start div, assert reset asynchronously in busy cycle 4 -> E_Busy=0, HI=LO=0 immediately, without waiting for a clock edge.
  - After release, a new mult completes normally in 5 cycles.
